// File: rtl/ladybird_config.sv
`default_nettype none
// ============================================================================
// Module   : ladybird_config
// Brief    : Shared ladybird constants, loader state type and address helper.
// Revision : 1.0
// ============================================================================
package ladybird_config;

    localparam int XLEN             = 32;
    localparam int LOADER_MAX_WORDS = 256;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        DATA  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } loader_state_t;

    // Byte address of word idx; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] loader_word_addr(
        input logic [XLEN-1:0] base,
        input logic [XLEN-1:0] idx
    );
        return base + (idx << 2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ladybird_program_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : ladybird_program_loader_if
// Brief    : Serial byte-in and instruction-bus write-out handshake bundle.
// Revision : 1.0
// ============================================================================
interface ladybird_program_loader_if;
    import ladybird_config::*;

    logic            rx_valid;
    logic [7:0]      rx_data;
    logic            rx_ready;
    logic            bus_req;
    logic            bus_gnt;
    logic [XLEN-1:0] bus_addr;
    logic [3:0]      bus_wstrb;
    logic [XLEN-1:0] bus_data;

    modport master (
        input  rx_valid, rx_data, bus_gnt,
        output rx_ready, bus_req, bus_addr, bus_wstrb, bus_data
    );

    modport slave (
        output rx_valid, rx_data, bus_gnt,
        input  rx_ready, bus_req, bus_addr, bus_wstrb, bus_data
    );

endinterface
`default_nettype wire

// File: rtl/ladybird_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : ladybird_byte_packer
// Brief    : Assembles 4 bytes LSB-first into a word; pulses on the 4th byte.
// Revision : 1.0
// ============================================================================
module ladybird_byte_packer (
    input  wire         clk,
    input  wire         nrst,
    input  wire         clr,
    input  wire         in_valid,
    input  wire  [7:0]  in_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  r_cnt;
    logic [23:0] r_shift;

    always_ff @(posedge clk) begin
        if (!nrst || clr) begin
            r_cnt   <= 2'd0;
            r_shift <= 24'd0;
        end else if (in_valid) begin
            r_cnt   <= r_cnt + 2'd1;
            r_shift <= {in_data, r_shift[23:8]};
        end
    end

    // The 4th byte is combined directly so the word is usable on its accept edge.
    assign word       = {in_data, r_shift};
    assign word_valid = in_valid && (r_cnt == 2'd3);

endmodule
`default_nettype wire

// File: rtl/ladybird_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : ladybird_program_loader
// Brief    : Loads a length-prefixed word image from serial into instruction
//            RAM, holding the core in reset until the image is complete.
// Revision : 1.0
// ============================================================================
module ladybird_program_loader
    import ladybird_config::*;
#(
    parameter logic [XLEN-1:0] BASE_ADDR = 32'h0000_0000,
    parameter int              MAX_WORDS = LOADER_MAX_WORDS,
    parameter int              CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  wire                         clk,
    input  wire                         nrst,
    ladybird_program_loader_if.master   ldr,
    input  wire                         restart,
    output logic                        core_nrst,
    output logic                        done,
    output logic                        error
);

    loader_state_t    r_state;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_index;

    logic        w_accept;
    logic        w_restart;
    logic        w_last;
    logic [31:0] w_word;
    logic        w_word_valid;

    assign w_accept  = ldr.rx_valid && ldr.rx_ready;
    assign w_restart = restart && ((r_state == DONE) || (r_state == ERR));
    assign w_last    = (r_index + CNT_W'(1)) == r_count;

    ladybird_byte_packer u_packer (
        .clk        (clk),
        .nrst       (nrst),
        .clr        (w_restart),
        .in_valid   (w_accept),
        .in_data    (ldr.rx_data),
        .word       (w_word),
        .word_valid (w_word_valid)
    );

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state       <= HDR;
            r_count       <= '0;
            r_index       <= '0;
            ldr.rx_ready  <= 1'b1;
            ldr.bus_req   <= 1'b0;
            ldr.bus_addr  <= BASE_ADDR;
            ldr.bus_wstrb <= 4'h0;
            ldr.bus_data  <= '0;
            core_nrst     <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
        end else begin
            case (r_state)
                HDR: begin
                    if (w_word_valid) begin
                        if (w_word == 32'd0) begin
                            r_state      <= DONE;
                            ldr.rx_ready <= 1'b0;
                            done         <= 1'b1;
                        end else if (w_word > 32'(MAX_WORDS)) begin
                            r_state      <= ERR;
                            ldr.rx_ready <= 1'b0;
                            error        <= 1'b1;
                        end else begin
                            r_state <= DATA;
                            r_count <= w_word[CNT_W-1:0];
                            r_index <= '0;
                        end
                    end
                end
                DATA: begin
                    if (w_word_valid) begin
                        r_state       <= WRITE;
                        ldr.rx_ready  <= 1'b0;
                        ldr.bus_req   <= 1'b1;
                        ldr.bus_addr  <= loader_word_addr(BASE_ADDR, XLEN'(r_index));
                        ldr.bus_data  <= w_word;
                        ldr.bus_wstrb <= 4'hF;
                    end
                end
                WRITE: begin
                    // Serial input stays stalled until the arbitrator takes the word.
                    if (ldr.bus_gnt) begin
                        ldr.bus_req   <= 1'b0;
                        ldr.bus_wstrb <= 4'h0;
                        r_index       <= r_index + CNT_W'(1);
                        if (w_last) begin
                            r_state <= DONE;
                            done    <= 1'b1;
                        end else begin
                            r_state      <= DATA;
                            ldr.rx_ready <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (restart) begin
                        r_state      <= HDR;
                        r_count      <= '0;
                        r_index      <= '0;
                        ldr.rx_ready <= 1'b1;
                        ldr.bus_addr <= BASE_ADDR;
                        core_nrst    <= 1'b0;
                        done         <= 1'b0;
                    end else begin
                        core_nrst <= 1'b1;
                    end
                end
                ERR: begin
                    if (restart) begin
                        r_state      <= HDR;
                        r_count      <= '0;
                        r_index      <= '0;
                        ldr.rx_ready <= 1'b1;
                        ldr.bus_addr <= BASE_ADDR;
                        error        <= 1'b0;
                    end
                    core_nrst <= 1'b0;
                end
                default: begin
                    r_state <= HDR;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ladybird_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ladybird_program_loader
// Brief    : Scoreboard bench for the program loader (two base addresses).
// Revision : 1.0
// ============================================================================
module tb_ladybird_program_loader;
    import ladybird_config::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       nrst;
    logic       restart;
    logic [1:0] rx_valid;
    logic [7:0] rx_data0;
    logic [7:0] rx_data1;
    logic [1:0] gnt;
    logic [1:0] core_nrst;
    logic [1:0] done;
    logic [1:0] error;

    int  total = 0;
    int  bad   = 0;
    int  req_cycles0 = 0;
    wr_t q0[$];
    wr_t q1[$];

    always #5 clk = ~clk;

    ladybird_program_loader_if if0 ();
    ladybird_program_loader_if if1 ();

    assign if0.rx_valid = rx_valid[0];
    assign if0.rx_data  = rx_data0;
    assign if0.bus_gnt  = gnt[0];
    assign if1.rx_valid = rx_valid[1];
    assign if1.rx_data  = rx_data1;
    assign if1.bus_gnt  = gnt[1];

    ladybird_program_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) u_dut0 (
        .clk(clk), .nrst(nrst), .ldr(if0), .restart(restart),
        .core_nrst(core_nrst[0]), .done(done[0]), .error(error[0])
    );

    ladybird_program_loader #(.BASE_ADDR(32'h0000_0100), .MAX_WORDS(256)) u_dut1 (
        .clk(clk), .nrst(nrst), .ldr(if1), .restart(restart),
        .core_nrst(core_nrst[1]), .done(done[1]), .error(error[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_write(input int sel, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s);
        wr_t e;
        if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
            total++;
            bad++;
            $display("FAIL wr%0d_unexpected: got addr %h data %h expected no write", sel, a, d);
            return;
        end
        if (sel == 0) e = q0.pop_front();
        else          e = q1.pop_front();
        chk($sformatf("wr%0d_addr", sel), a, e.addr);
        chk($sformatf("wr%0d_data", sel), d, e.data);
        chk($sformatf("wr%0d_wstrb", sel), 32'(s), 32'hF);
    endtask

    // Monitors: a write happens at the posedge following a negedge with req && gnt.
    always @(negedge clk) begin
        if (if0.bus_req) req_cycles0++;
        if (nrst && if0.bus_req && gnt[0]) check_write(0, if0.bus_addr, if0.bus_data, if0.bus_wstrb);
    end

    always @(negedge clk) begin
        if (nrst && if1.bus_req && gnt[1]) check_write(1, if1.bus_addr, if1.bus_data, if1.bus_wstrb);
    end

    function automatic logic rdy(input int sel);
        return (sel == 0) ? if0.rx_ready : if1.rx_ready;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b);
        logic taken;
        logic r;
        taken = 1'b0;
        rx_valid[sel] = 1'b1;
        if (sel == 0) rx_data0 = b;
        else          rx_data1 = b;
        for (int i = 0; i < 50 && !taken; i++) begin
            @(negedge clk);
            r = rdy(sel);
            tick();
            taken = r;
        end
        rx_valid[sel] = 1'b0;
        if (!taken) begin
            total++;
            bad++;
            $display("FAIL send_timeout%0d: got no accept expected accept of %h", sel, b);
        end
    endtask

    task automatic send_word(input int sel, input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(sel, w[8*i +: 8]);
            repeat (gap) tick();
        end
    endtask

    task automatic wait_done(input int sel);
        for (int i = 0; i < 200 && !done[sel]; i++) tick();
        chk($sformatf("wait_done%0d", sel), 32'(done[sel]), 32'd1);
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
    endtask

    task automatic check_reset0(input string tag);
        chk({tag, "_rx_ready"}, 32'(if0.rx_ready), 32'd1);
        chk({tag, "_bus_req"}, 32'(if0.bus_req), 32'd0);
        chk({tag, "_bus_addr"}, if0.bus_addr, 32'h0);
        chk({tag, "_bus_wstrb"}, 32'(if0.bus_wstrb), 32'd0);
        chk({tag, "_bus_data"}, if0.bus_data, 32'h0);
        chk({tag, "_core_nrst"}, 32'(core_nrst[0]), 32'd0);
        chk({tag, "_done"}, 32'(done[0]), 32'd0);
        chk({tag, "_error"}, 32'(error[0]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved;
        nrst     = 1'b0;
        restart  = 1'b0;
        rx_valid = 2'b00;
        rx_data0 = 8'h00;
        rx_data1 = 8'h00;
        gnt      = 2'b11;
        repeat (3) tick();
        check_reset0("reset");
        chk("reset_addr1", if1.bus_addr, 32'h100);
        nrst = 1'b1;
        tick();

        // Two-word image, immediate grant.
        q0.push_back('{32'h0, 32'hFFF0_0093});
        q0.push_back('{32'h4, 32'h0000_8103});
        send_word(0, 32'd2, 0);
        send_word(0, 32'hFFF0_0093, 0);
        send_word(0, 32'h0000_8103, 0);
        tick();
        chk("img2_done", 32'(done[0]), 32'd1);
        chk("img2_core_nrst_entry", 32'(core_nrst[0]), 32'd0);
        chk("img2_rx_ready", 32'(if0.rx_ready), 32'd0);
        tick();
        chk("img2_core_nrst", 32'(core_nrst[0]), 32'd1);
        pulse_restart();
        chk("restart_done", 32'(done[0]), 32'd0);
        chk("restart_core_nrst", 32'(core_nrst[0]), 32'd0);
        chk("restart_rx_ready", 32'(if0.rx_ready), 32'd1);

        // Empty image.
        saved = req_cycles0;
        send_word(0, 32'd0, 0);
        chk("zero_done", 32'(done[0]), 32'd1);
        chk("zero_bus_req", 32'(if0.bus_req), 32'd0);
        tick();
        chk("zero_core_nrst", 32'(core_nrst[0]), 32'd1);
        chk("zero_no_req", 32'(req_cycles0), 32'(saved));
        pulse_restart();

        // Oversized header 0x101.
        send_word(0, 32'h0000_0101, 0);
        chk("err_error", 32'(error[0]), 32'd1);
        chk("err_core_nrst", 32'(core_nrst[0]), 32'd0);
        chk("err_rx_ready", 32'(if0.rx_ready), 32'd0);
        rx_valid[0] = 1'b1;
        repeat (3) tick();
        rx_valid[0] = 1'b0;
        chk("err_sticky", 32'(error[0]), 32'd1);
        chk("err_rx_ready_held", 32'(if0.rx_ready), 32'd0);
        chk("err_no_req", 32'(req_cycles0), 32'(saved));
        pulse_restart();
        chk("err_restart_error", 32'(error[0]), 32'd0);
        chk("err_restart_rx_ready", 32'(if0.rx_ready), 32'd1);

        // One word with grant withheld for 7 cycles.
        gnt[0] = 1'b0;
        q0.push_back('{32'h0, 32'hDEAD_BEEF});
        send_word(0, 32'd1, 0);
        send_word(0, 32'hDEAD_BEEF, 0);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("stall%0d_req", k), 32'(if0.bus_req), 32'd1);
            chk($sformatf("stall%0d_addr", k), if0.bus_addr, 32'h0);
            chk($sformatf("stall%0d_data", k), if0.bus_data, 32'hDEAD_BEEF);
            chk($sformatf("stall%0d_rx_ready", k), 32'(if0.rx_ready), 32'd0);
            if (k < 6) tick();
        end
        gnt[0] = 1'b1;
        tick();
        chk("stall_done", 32'(done[0]), 32'd1);
        chk("stall_req_drop", 32'(if0.bus_req), 32'd0);
        pulse_restart();

        // Reset after two data bytes, then a clean one-word load.
        send_word(0, 32'd1, 0);
        send_byte(0, 8'h11);
        send_byte(0, 8'h22);
        nrst = 1'b0;
        tick();
        check_reset0("midreset");
        nrst = 1'b1;
        q0.push_back('{32'h0, 32'h1122_3344});
        send_word(0, 32'd1, 0);
        send_word(0, 32'h1122_3344, 0);
        wait_done(0);

        // Non-zero base, three words with gaps in rx_valid.
        q1.push_back('{32'h100, 32'h0123_4567});
        q1.push_back('{32'h104, 32'h89AB_CDEF});
        q1.push_back('{32'h108, 32'hCAFE_F00D});
        send_word(1, 32'd3, 1);
        send_word(1, 32'h0123_4567, 2);
        send_word(1, 32'h89AB_CDEF, 1);
        send_word(1, 32'hCAFE_F00D, 3);
        wait_done(1);
        chk("base_error", 32'(error[1]), 32'd0);

        repeat (2) tick();
        chk("q0_empty", 32'(q0.size()), 32'd0);
        chk("q1_empty", 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
